data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Word-organised data memory sitting at the far end of the ALU address path: the ALU result is the load/store address, and this block is the responder that services the access.
- Supports RISC-V byte/half/word loads (signed and unsigned) and stores, little-endian.
- Access latency is set by a parameter, and completion is signalled with a one-cycle ready pulse, so the core stalls until the access completes.

Parameters:
- MEMORY_DEPTH, 64, number of 32-bit words.
- DATA_WIDTH, 32, word width (fixed at 32 for RV32).
- WAIT_STATES, 2, extra cycles between accept and response (0 allowed).
- BASE_ADDR, 32'h1001_0000, byte address of word 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Req_i  input  1  access request, sampled in IDLE only.
- Write_i  input  1  1 = store, 0 = load.
- Size_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
- Unsigned_i  input  1  1 = zero-extend load (LBU/LHU), 0 = sign-extend.
- Address_i  input  32  byte address from ALU result.
- Write_Data_i  input  32  store data, right-aligned (rs2).
- Ready_o  output  1  one-cycle completion pulse.
- Read_Data_o  output  32  load result, extended; valid only while Ready_o=1.
- Error_o  output  1  access fault, valid only while Ready_o=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE, wait counter = 0.
  - Ready_o=0, Read_Data_o=0, Error_o=0.
  - Memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a rising edge with Req_i=1, capture Write_i, Size_i, Unsigned_i, Address_i and Write_Data_i.
  - If WAIT_STATES>0, go to WAIT with counter=WAIT_STATES-1; otherwise go to RESP.
- WAIT: decrement the counter each cycle; go to RESP when the counter reaches 0.
- RESP:
  - Registered outputs: Ready_o=1 for exactly one cycle, then return to IDLE.
  - Ready_o is high during the (1+WAIT_STATES)-th cycle after the accept edge.
  - Req_i is ignored in WAIT and RESP. Earliest next accept is the edge that ends RESP, so back-to-back requests take a period of WAIT_STATES+2 cycles.
- Address decode:
  - offset = captured address − BASE_ADDR.
  - Word index = offset[31:2]; byte lane = offset[1:0].
- Fault conditions; any one sets Error_o=1 with Ready_o, Read_Data_o=0, and no memory write:
  - Size=11.
  - Half access with lane[0]=1.
  - Word access with lane≠0.
  - Address below BASE_ADDR, or word index ≥ MEMORY_DEPTH.
- Store without fault:
  - The write commits on the edge entering RESP.
  - Byte writes lane byte = Write_Data_i[7:0]; half writes lanes {lane+1, lane} = Write_Data_i[15:0]; word writes the full word.
  - Other bytes are unchanged. Read_Data_o=0 during the store response.
- Load without fault:
  - Select the lane byte or half from the addressed word.
  - Sign-extend (Unsigned_i=0) or zero-extend (Unsigned_i=1); a word load is passed through unchanged.
- Reset asserted mid-access: the access is aborted, a pending store is not written, and the state returns to IDLE.
- Read and write of the same word in consecutive accesses: the load returns the newly stored data (no bypass is needed because accesses serialise).

Test Plan:
- WAIT_STATES=2: store word 32'hDEADBEEF at 32'h1001_0004 with Req_i at edge 0 -> Ready_o=1 in cycle 3 only, Error_o=0. Then load word from the same address -> Read_Data_o=32'hDEADBEEF.
- Load byte from 32'h1001_0007 with Unsigned_i=0 -> 32'hFFFFFFDE; same access with Unsigned_i=1 -> 32'h000000DE. Load half from 32'h1001_0004, signed -> 32'hFFFFBEEF.
- Store byte 32'h0000_0055 to 32'h1001_0005 over word DEADBEEF -> subsequent word load returns 32'hDEAD55EF.
- Half store to 32'h1001_0001, word load from 32'h1001_0002, and load from 32'h1001_0100 (index 64) -> each gives Ready_o=1 with Error_o=1, Read_Data_o=0, and memory unchanged.
- WAIT_STATES=0: Req_i held high continuously -> Ready_o pulses every 2nd cycle. Req_i pulsed during WAIT -> ignored, no extra Ready_o.
- Store accepted, reset pulled low for 1 cycle during WAIT -> no Ready_o, all outputs 0, and a word load afterwards returns the old contents.

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder: word-organised RV32 data memory servicing byte/half/word loads and stores
// after WAIT_STATES extra cycles, completing with a one-cycle Ready_o pulse.
// Ports: clk, reset (async active-low); Req_i/Write_i/Size_i/Unsigned_i/Address_i/Write_Data_i
// describe the access; Ready_o pulses on completion with Read_Data_o (extended load) and Error_o.
module data_memory_responder #(
  parameter int          MEMORY_DEPTH = 64,
  parameter int          DATA_WIDTH   = 32,
  parameter int          WAIT_STATES  = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req_i,
  input  logic                  Write_i,
  input  logic [1:0]            Size_i,
  input  logic                  Unsigned_i,
  input  logic [31:0]           Address_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  output logic                  Ready_o,
  output logic [DATA_WIDTH-1:0] Read_Data_o,
  output logic                  Error_o
);
  localparam int IW = MEMORY_DEPTH > 1 ? $clog2(MEMORY_DEPTH) : 1;
  localparam int CW = WAIT_STATES > 1 ? $clog2(WAIT_STATES) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    write_q, unsigned_q, ready_q, ready_d, error_q, error_d;
  logic [1:0]              size_q;
  logic [31:0]             addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   mem [MEMORY_DEPTH];
  logic                    idle, a_write, a_uns, in_range, fault, we;
  logic [1:0]              a_size, lane;
  logic [31:0]             a_addr, offset;
  logic [DATA_WIDTH-1:0]   a_wdata, word, shifted, wmerge, lval;
  logic [IW-1:0]           idx;
  logic [3:0]              be;
  // Decode from live inputs on the accept edge, captured copies afterwards, so a
  // zero-wait-state access can respond straight out of IDLE.
  assign idle     = state_q == S_IDLE;
  assign a_write  = idle ? Write_i      : write_q;
  assign a_uns    = idle ? Unsigned_i   : unsigned_q;
  assign a_size   = idle ? Size_i       : size_q;
  assign a_addr   = idle ? Address_i    : addr_q;
  assign a_wdata  = idle ? Write_Data_i : wdata_q;
  assign offset   = a_addr - BASE_ADDR;
  assign lane     = offset[1:0];
  assign idx      = offset[IW+1:2];
  assign in_range = a_addr >= BASE_ADDR && offset[31:2] < 30'(MEMORY_DEPTH);
  assign fault    = !in_range || a_size == 2'b11 || (a_size == 2'b01 && lane[0]) ||
                    (a_size == 2'b10 && lane != 2'b00);
  assign word     = in_range ? mem[idx] : '0;
  assign shifted  = word >> {lane, 3'b000};
  assign lval     = a_size == 2'b00 ? {{24{~a_uns & shifted[7]}}, shifted[7:0]} :
                    a_size == 2'b01 ? {{16{~a_uns & shifted[15]}}, shifted[15:0]} : word;
  assign be       = a_size == 2'b00 ? 4'b0001 << lane : a_size == 2'b01 ? 4'b0011 << lane : 4'b1111;
  assign wmerge   = a_size == 2'b00 ? {4{a_wdata[7:0]}} : a_size == 2'b01 ? {2{a_wdata[15:0]}} : a_wdata;
  // Gated by reset so a store presented while reset is held can never commit.
  assign we       = reset && state_d == S_RESP && a_write && !fault;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE && Req_i) begin
      state_d = WAIT_STATES == 0 ? S_RESP : S_WAIT;
      cnt_d   = CW'(WAIT_STATES - 1);
    end else if (state_q == S_WAIT) begin
      state_d = cnt_q == '0 ? S_RESP : S_WAIT;
      cnt_d   = cnt_q - CW'(1);
    end else if (state_q == S_RESP) begin
      state_d = S_IDLE;
    end
    ready_d = state_d == S_RESP;
    error_d = ready_d && fault;
    rdata_d = ready_d && !fault && !a_write ? lval : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      rdata_q    <= '0;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
      if (idle && Req_i) begin
        write_q    <= Write_i;
        unsigned_q <= Unsigned_i;
        size_q     <= Size_i;
        addr_q     <= Address_i;
        wdata_q    <= Write_Data_i;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wmerge[8*b +: 8];
  end
  assign Ready_o     = ready_q;
  assign Read_Data_o = rdata_q;
  assign Error_o     = error_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: scoreboard bench driving a 0-wait and a 2-wait responder with shared inputs
module tb_data_memory_responder;
  localparam logic [31:0] BASE = 32'h1001_0000;
  typedef struct {logic [31:0] data; logic err; int cyc;} exp_t;
  logic clk = 0, rst_n = 0, req0 = 0, req2 = 0, wr = 0, uns = 0;
  logic [1:0] sz = 0;
  logic [31:0] addr = 0, wd = 0;
  logic rdy0, rdy2, err0, err2;
  logic [31:0] rd0, rd2;
  int cyc = 0, n_cmp = 0, n_fail = 0, rc0 = 0, rc2 = 0;
  exp_t q0[$], q2[$];
  exp_t m0, m2;
  logic [7:0] mb [256];
  data_memory_responder #(.WAIT_STATES(0)) dut0 (.clk(clk), .reset(rst_n), .Req_i(req0), .Write_i(wr),
    .Size_i(sz), .Unsigned_i(uns), .Address_i(addr), .Write_Data_i(wd), .Ready_o(rdy0),
    .Read_Data_o(rd0), .Error_o(err0));
  data_memory_responder #(.WAIT_STATES(2)) dut2 (.clk(clk), .reset(rst_n), .Req_i(req2), .Write_i(wr),
    .Size_i(sz), .Unsigned_i(uns), .Address_i(addr), .Write_Data_i(wd), .Ready_o(rdy2),
    .Read_Data_o(rd2), .Error_o(err2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // Reference: byte-addressed little-endian array, values assembled byte by byte.
  function automatic exp_t model(input bit w, input logic [1:0] s, input bit u, input logic [31:0] a,
                                 input logic [31:0] d);
    exp_t e;
    longint off = longint'(a) - longint'(BASE);
    int n = 1 << s;
    logic [31:0] v = 0;
    e.cyc = 0;
    e.data = 0;
    e.err = s == 3 || off < 0 || off >= 256 || (off % n) != 0;
    if (!e.err) begin
      if (w) for (int i = 0; i < n; i++) mb[off + i] = 8'(d >> (8 * i));
      else begin
        for (int i = 0; i < n; i++) v |= 32'(mb[off + i]) << (8 * i);
        if (!u && n < 4 && v[8 * n - 1]) v |= ~((32'd1 << (8 * n)) - 1);
        e.data = v;
      end
    end
    return e;
  endfunction
  task automatic drain();
    for (int i = 0; i < 20 && (q0.size() != 0 || q2.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    chk("drain_pending", 32'(q0.size() + q2.size()), 0);
    q0.delete(); q2.delete();
  endtask
  task automatic issue(input bit w, input logic [1:0] s, input bit u, input logic [31:0] a,
                       input logic [31:0] d, input bit hold = 0);
    exp_t e;
    e = model(w, s, u, a, d);
    e.cyc = cyc + 1; q0.push_back(e);
    e.cyc = cyc + 3; q2.push_back(e);
    wr = w; sz = s; uns = u; addr = a; wd = d; req0 = 1; req2 = 1;
    @(posedge clk); #1;
    if (hold) begin
      addr = a + 16; wr = 0;
      @(posedge clk); #1;
    end
    req0 = 0; req2 = 0;
    drain();
  endtask
  always @(negedge clk) begin
    if (rdy0) begin
      rc0++;
      if (q0.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_ready0: got ready=1 expected ready=0 at cycle %0d", cyc);
      end else begin
        m0 = q0.pop_front();
        chk("rdata0", rd0, m0.data);
        chk("error0", 32'(err0), 32'(m0.err));
        chk("ready_cycle0", 32'(cyc), 32'(m0.cyc));
      end
    end
    if (rdy2) begin
      rc2++;
      if (q2.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_ready2: got ready=1 expected ready=0 at cycle %0d", cyc);
      end else begin
        m2 = q2.pop_front();
        chk("rdata2", rd2, m2.data);
        chk("error2", 32'(err2), 32'(m2.err));
        chk("ready_cycle2", 32'(cyc), 32'(m2.cyc));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    exp_t e;
    int c, r, k;
    logic [31:0] a, old;
    repeat (2) @(posedge clk); #1;
    chk("rst_ready0", 32'(rdy0), 0); chk("rst_rdata0", rd0, 0); chk("rst_error0", 32'(err0), 0);
    chk("rst_ready2", 32'(rdy2), 0); chk("rst_rdata2", rd2, 0); chk("rst_error2", 32'(err2), 0);
    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) issue(1, 2'b10, 0, BASE + 32'(4 * i), $urandom);
    issue(1, 2'b10, 0, BASE + 4, 32'hDEADBEEF);
    issue(0, 2'b10, 0, BASE + 4, 0);
    issue(0, 2'b00, 0, BASE + 7, 0);
    issue(0, 2'b00, 1, BASE + 7, 0);
    issue(0, 2'b01, 0, BASE + 4, 0);
    issue(1, 2'b00, 0, BASE + 5, 32'h0000_0055);
    issue(0, 2'b10, 0, BASE + 4, 0);
    issue(1, 2'b01, 0, BASE + 1, 32'h1234_5678);
    issue(0, 2'b10, 0, BASE + 2, 0);
    issue(0, 2'b10, 0, BASE + 32'h100, 0);
    issue(1, 2'b10, 0, BASE - 4, 32'hCAFE_F00D);
    issue(1, 2'b11, 0, BASE + 8, 32'hCAFE_F00D);
    issue(0, 2'b10, 0, BASE, 0);
    issue(0, 2'b10, 0, BASE + 4, 0);
    issue(0, 2'b10, 0, BASE + 8, 0);
    issue(0, 2'b10, 0, BASE + 12, 0, 1);
    // Req held high for 12 edges: 0-wait accepts every 2nd edge, 2-wait every 4th.
    e = model(0, 2'b10, 0, BASE + 4, 0);
    c = cyc;
    for (int i = 0; i < 6; i++) begin e.cyc = c + 1 + 2 * i; q0.push_back(e); end
    for (int i = 0; i < 3; i++) begin e.cyc = c + 3 + 4 * i; q2.push_back(e); end
    wr = 0; sz = 2'b10; uns = 0; addr = BASE + 4; req0 = 1; req2 = 1;
    repeat (12) @(posedge clk);
    #1; req0 = 0; req2 = 0;
    drain();
    // Store to the 2-wait responder aborted by reset while waiting.
    old = {mb[23], mb[22], mb[21], mb[20]};
    wr = 1; sz = 2'b10; addr = BASE + 20; wd = ~old; req2 = 1;
    @(posedge clk); #1;
    req2 = 0; rst_n = 0;
    #2;
    chk("abort_ready2", 32'(rdy2), 0); chk("abort_rdata2", rd2, 0); chk("abort_error2", 32'(err2), 0);
    @(posedge clk); #1;
    rst_n = 1; r = rc2;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_ready2", 32'(rc2), 32'(r));
    issue(0, 2'b10, 0, BASE + 20, 0);
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 9);
      a = k == 0 ? BASE - 32'($urandom_range(1, 64)) :
          k == 1 ? BASE + 256 + 32'($urandom_range(0, 64)) : BASE + 32'($urandom_range(0, 255));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
